fpu_result_merge: RTL and testbench
===================================

Name: fpu_result_merge

Overview:
- Output stage of the FPU add/sub path. It merges the exception classifier's verdict (exception_flag, copied_operand) with the normal adder datapath result to form the final IEEE-754 single-precision result.
- At issue it captures per-operation sideband: operand signs, operation select, and A-is-infinity.
- It aligns that sideband with the classifier output, which arrives EXC_LATENCY cycles after issue.
- It queues the aligned records in order and pairs each one with the datapath result when dp_valid arrives.

Parameters:
- WIDTH, 32, total float width.
- EXP_BITS, 8, exponent width.
- MANT_BITS, 23, fraction width.
- EXC_LATENCY, 2, cycles from in_valid to a valid exception_flag/copied_operand. Allowed range 1..4.
- DEPTH, 4, record FIFO entries. Must be a power of 2, at least 2.

Ports:
- clk, input, 1, clock (rising edge).
- arst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operation issued this cycle; a/b/operation_select valid.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- operation_select, input, 1, 0=add, 1=sub.
- exception_flag, input, 3, classifier verdict, valid EXC_LATENCY cycles after in_valid.
- copied_operand, input, WIDTH-1, classifier {exp,frac}, same timing as exception_flag.
- dp_valid, input, 1, adder datapath result valid (in issue order).
- dp_result, input, WIDTH, adder datapath result.
- clr_err, input, 1, synchronous clear of sticky error flags.
- out_valid, output, 1, result valid (1-cycle pulse per dp_valid).
- result, output, WIDTH, final result.
- result_flag, output, 3, flag used for this result.
- fifo_count, output, clog2(DEPTH)+1, record FIFO occupancy.
- err_overflow, output, 1, sticky: record dropped because the FIFO was full.
- err_underflow, output, 1, sticky: dp_valid arrived with the FIFO empty.

Behaviour:
- Reset (arst_n=0, asynchronous): all outputs 0; FIFO pointers and count 0; sideband delay line cleared.
- Sideband delay line: shift register of depth EXC_LATENCY carrying {in_valid, a[WIDTH-1], b[WIDTH-1], operation_select, a_inf}.
  - a_inf = (a exponent all ones && a fraction == 0).
- Push: when the delay-line tail valid bit = 1, push record {exception_flag, copied_operand, a_sign, b_sign, op, a_inf} on that clock edge.
- Pop: dp_valid=1 pops the head.
  - Next cycle: out_valid=1, result and result_flag registered. Latency dp_valid -> out_valid is 1 cycle.
  - out_valid=0 in every cycle without a pop.
- Result per flag, where s_a/s_b = stored signs and C = copied_operand:
  - 000 NONE: dp_result.
  - 001 NAN: 32'h7FC00000 (quiet NaN, positive).
  - 010 COPY_A: a_inf ? {s_a, 8'hFF, 23'b0} : {s_a, C}.
  - 011 COPY_B: {s_b, C}.
  - 100 FIN_MIN_INF: {~s_b, 8'hFF, 23'b0}.
  - 101 ZERO_MIN_ZERO: {sz, 31'b0}, where sz = op ? (s_a & ~s_b) : (s_a & s_b).
  - 110 ZERO_MIN_SOME: {~s_b, C}.
  - 111 SUB_SAME_VAL: 32'h00000000.
- Push and pop in the same cycle: both performed; count unchanged; FIFO order preserved.
- Push when full:
  - With a simultaneous pop: accepted.
  - Without a pop: record dropped, err_overflow set, count stays DEPTH.
- Pop when empty (including a simultaneous push): no bypass.
  - out_valid=1, result=dp_result, result_flag=000.
  - err_underflow set; the simultaneous push still occurs.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- clr_err=1 clears both sticky errors. If an error event occurs in the same cycle, the set wins.
- in_valid may be asserted every cycle; the delay line has no backpressure.
- Reset mid-operation flushes all in-flight records.

Test Plan:
- Reset: assert arst_n=0 mid-stream -> out_valid, result, fifo_count and errors read 0 immediately, with no clock edge needed.
- NONE flag:
  - Stimulus: a=3F800000, b=40000000, add; flag 000 at issue+2; dp_valid with dp_result=40400000 at issue+4.
  - Response: out_valid one cycle later, result=40400000, result_flag=000.
- Infinity cases:
  - a=7F800000, b=FF800000, sub, flag 010, C=0 -> result=7F800000.
  - a=3F800000, b=7F800000, sub, flag 100 -> result=FF800000.
- Zero cases:
  - a=80000000, b=00000000, sub, flag 101 -> result=80000000.
  - a=80000000, b=80000000, add -> 80000000.
  - a=00000000, b=80000000, add -> 00000000.
  - flag 110 with b=40A00000 -> result=C0A00000.
  - flag 111 -> result=00000000.
- Back-to-back ordering: 4 issues on consecutive cycles with distinct flags, dp_valid delayed so the FIFO reaches 4 -> fifo_count=4, then results emerge in issue order.
- Overflow/underflow:
  - 5th issue with no pop -> err_overflow=1, count stays 4.
  - dp_valid with the FIFO empty -> result=dp_result, err_underflow=1.
  - clr_err -> both errors 0.

Source files
------------

// File: rtl/fpu_result_merge.sv
// FPU add/sub output stage: aligns issue-time sideband with the exception classifier
// verdict, queues it in order, and merges it with the adder datapath result.
module fpu_result_merge #(
    parameter int WIDTH       = 32,
    parameter int EXP_BITS    = 8,
    parameter int MANT_BITS   = 23,
    parameter int EXC_LATENCY = 2,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         operation_select,
    input  logic [2:0]                   exception_flag,
    input  logic [WIDTH-2:0]             copied_operand,
    input  logic                         dp_valid,
    input  logic [WIDTH-1:0]             dp_result,
    input  logic                         clr_err,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             result,
    output logic [2:0]                   result_flag,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic                         err_overflow,
    output logic                         err_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        FLAG_NONE          = 3'b000,
        FLAG_NAN           = 3'b001,
        FLAG_COPY_A        = 3'b010,
        FLAG_COPY_B        = 3'b011,
        FLAG_FIN_MIN_INF   = 3'b100,
        FLAG_ZERO_MIN_ZERO = 3'b101,
        FLAG_ZERO_MIN_SOME = 3'b110,
        FLAG_SUB_SAME_VAL  = 3'b111
    } flag_e;

    // Delay-line entry layout: {valid, a_sign, b_sign, op, a_inf}
    logic [4:0]          dly_q [EXC_LATENCY];
    logic                a_inf;
    logic [4:0]          tail;
    logic                push_req;

    logic [2:0]          mem_flag [DEPTH];
    logic [WIDTH-2:0]    mem_copy [DEPTH];
    logic [3:0]          mem_side [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                empty;
    logic                full;
    logic                do_push;
    logic                do_pop;

    logic [2:0]          h_flag;
    logic [WIDTH-2:0]    h_copy;
    logic                h_sa;
    logic                h_sb;
    logic                h_op;
    logic                h_ainf;
    logic [2:0]          sel_flag;
    logic [WIDTH-1:0]    merged;

    assign a_inf    = (&a[WIDTH-2 -: EXP_BITS]) && ~(|a[MANT_BITS-1:0]);
    assign tail     = dly_q[EXC_LATENCY-1];
    assign push_req = tail[4];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < EXC_LATENCY; i++) dly_q[i] <= '0;
        end else begin
            dly_q[0] <= {in_valid, a[WIDTH-1], b[WIDTH-1], operation_select, a_inf};
            for (int i = 1; i < EXC_LATENCY; i++) dly_q[i] <= dly_q[i-1];
        end
    end

    assign empty = (fifo_count == '0);
    assign full  = (fifo_count == FULL_COUNT);
    // A full FIFO still accepts a record when the head leaves in the same cycle
    assign do_pop  = dp_valid && !empty;
    assign do_push = push_req && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_flag[wr_ptr] <= exception_flag;
            mem_copy[wr_ptr] <= copied_operand;
            mem_side[wr_ptr] <= tail[3:0];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      fifo_count <= fifo_count + CW'(1);
            else if (do_pop && !do_push) fifo_count <= fifo_count - CW'(1);
        end
    end

    assign h_flag = mem_flag[rd_ptr];
    assign h_copy = mem_copy[rd_ptr];
    assign {h_sa, h_sb, h_op, h_ainf} = mem_side[rd_ptr];
    // An underflowing pop has no record, so it falls through to the raw datapath result
    assign sel_flag = empty ? FLAG_NONE : h_flag;

    always_comb begin
        merged = dp_result;
        unique case (flag_e'(sel_flag))
            FLAG_NONE:          merged = dp_result;
            FLAG_NAN:           merged = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
            FLAG_COPY_A:        merged = h_ainf ? {h_sa, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}}
                                                : {h_sa, h_copy};
            FLAG_COPY_B:        merged = {h_sb, h_copy};
            FLAG_FIN_MIN_INF:   merged = {~h_sb, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
            FLAG_ZERO_MIN_ZERO: merged = {(h_op ? (h_sa & ~h_sb) : (h_sa & h_sb)), {(WIDTH-1){1'b0}}};
            FLAG_ZERO_MIN_SOME: merged = {~h_sb, h_copy};
            FLAG_SUB_SAME_VAL:  merged = '0;
            default:            merged = dp_result;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid     <= 1'b0;
            result        <= '0;
            result_flag   <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            out_valid <= dp_valid;
            if (dp_valid) begin
                result      <= merged;
                result_flag <= sel_flag;
            end
            err_overflow  <= (err_overflow && !clr_err) || (push_req && full && !dp_valid);
            err_underflow <= (err_underflow && !clr_err) || (dp_valid && empty);
        end
    end

endmodule

// File: tb/tb_fpu_result_merge.sv
// Randomized scoreboard bench for fpu_result_merge against a queue-based reference model.
module tb_fpu_result_merge;

    localparam int L = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        operation_select = 1'b0;
    logic [2:0]  exception_flag = '0;
    logic [30:0] copied_operand = '0;
    logic        dp_valid = 1'b0;
    logic [31:0] dp_result = '0;
    logic        clr_err = 1'b0;
    logic        out_valid;
    logic [31:0] result;
    logic [2:0]  result_flag;
    logic [2:0]  fifo_count;
    logic        err_overflow;
    logic        err_underflow;

    fpu_result_merge #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .EXC_LATENCY(L), .DEPTH(D)) dut (
        .clk(clk), .arst_n(arst_n), .in_valid(in_valid), .a(a), .b(b),
        .operation_select(operation_select), .exception_flag(exception_flag),
        .copied_operand(copied_operand), .dp_valid(dp_valid), .dp_result(dp_result),
        .clr_err(clr_err), .out_valid(out_valid), .result(result), .result_flag(result_flag),
        .fifo_count(fifo_count), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        sa;
        logic        sb;
        logic        op;
        logic        ainf;
        logic [2:0]  flag;
        logic [30:0] copy;
    } rec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flag;
    } exp_t;

    rec_t pipe[$];
    rec_t m_q[$];
    exp_t exp_q[$];
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;
    int   checks = 0;
    int   failures = 0;

    function automatic logic [31:0] ref_result(rec_t r, logic [31:0] dp);
        case (r.flag)
            3'd0: return dp;
            3'd1: return 32'h7FC00000;
            3'd2: return r.ainf ? {r.sa, 31'h7F800000} : {r.sa, r.copy};
            3'd3: return {r.sb, r.copy};
            3'd4: return {~r.sb, 31'h7F800000};
            3'd5: return (r.op ? (r.sa && !r.sb) : (r.sa && r.sb)) ? 32'h80000000 : 32'h0;
            3'd6: return {~r.sb, r.copy};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 7))
            0: return {s, 31'h7F800000};
            1: return {s, 31'h0};
            2: return {s, 8'hFF, 23'($urandom_range(1, 1000))};
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        rec_t idle;
        idle = '{default: '0};
        pipe.delete();
        for (int i = 0; i < L; i++) pipe.push_back(idle);
        m_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock cycle: check state from the previous edge, drive inputs, advance the model
    task automatic applyStimulus(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                                 input logic opv, input logic [2:0] fl, input logic [30:0] cp,
                                 input logic dpv, input logic [31:0] dp, input logic clr);
        rec_t tl, nw, r;
        exp_t e;
        logic new_ovf, new_unf;
        @(negedge clk);
        checkOutput("fifo_count", 32'(fifo_count), m_q.size());
        checkOutput("err_overflow", 32'(err_overflow), 32'(m_ovf));
        checkOutput("err_underflow", 32'(err_underflow), 32'(m_unf));
        tl = pipe[$];
        pipe.pop_back();
        nw.v = iv; nw.sa = av[31]; nw.sb = bv[31]; nw.op = opv;
        nw.ainf = (av[30:23] == 8'hFF) && (av[22:0] == 23'h0);
        nw.flag = fl; nw.copy = cp;
        pipe.push_front(nw);
        in_valid = iv; a = av; b = bv; operation_select = opv;
        dp_valid = dpv; dp_result = dp; clr_err = clr;
        exception_flag = tl.v ? tl.flag : 3'($urandom);
        copied_operand = tl.v ? tl.copy : 31'($urandom);
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (dpv) begin
            if (m_q.size() == 0) begin
                e.res = dp; e.flag = 3'd0; new_unf = 1'b1;
            end else begin
                r = m_q.pop_front();
                e.res = ref_result(r, dp); e.flag = r.flag;
            end
            exp_q.push_back(e);
        end
        if (tl.v) begin
            if (m_q.size() < D) m_q.push_back(tl);
            else new_ovf = 1'b1;
        end
        m_ovf = (m_ovf && !clr) || new_ovf;
        m_unf = (m_unf && !clr) || new_unf;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic doReset();
        #1 arst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_result", result, 32'h0);
        checkOutput("rst_result_flag", 32'(result_flag), 32'h0);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'h0);
        checkOutput("rst_errors", {30'h0, err_overflow, err_underflow}, 32'h0);
        clearModel();
        in_valid = 1'b0; dp_valid = 1'b0; clr_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Issue one op, then pop its record four cycles after issue
    task automatic dirOp(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                         input logic [2:0] fl, input logic [30:0] cp, input logic [31:0] dp);
        applyStimulus(1'b1, av, bv, opv, fl, cp, 1'b0, '0, 1'b0);
        repeat (3) idleCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, dp, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_out_valid: got result %h with nothing pending", result);
            end else begin
                e = exp_q.pop_front();
                checkOutput("result", result, e.res);
                checkOutput("result_flag", 32'(result_flag), 32'(e.flag));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearModel();
        #2;
        doReset();

        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(0, 9) < 6), pick_val(), pick_val(), 1'($urandom),
                          3'($urandom), 31'($urandom), ($urandom_range(0, 9) < 3), $urandom,
                          ($urandom_range(0, 19) == 0));
        // Reset in the middle of traffic, between clock edges
        doReset();
        for (int i = 0; i < 300; i++)
            applyStimulus(($urandom_range(0, 9) < 3), pick_val(), pick_val(), 1'($urandom),
                          3'($urandom), 31'($urandom), ($urandom_range(0, 9) < 6), $urandom,
                          ($urandom_range(0, 19) == 0));
        doReset();

        dirOp(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 31'h1234, 32'h40400000);
        dirOp(32'h7F800000, 32'hFF800000, 1'b1, 3'b010, 31'h0, 32'hDEADBEEF);
        dirOp(32'h3F800000, 32'h7F800000, 1'b1, 3'b100, 31'h0, 32'hDEADBEEF);
        dirOp(32'h80000000, 32'h00000000, 1'b1, 3'b101, 31'h0, 32'hDEADBEEF);
        dirOp(32'h80000000, 32'h80000000, 1'b0, 3'b101, 31'h0, 32'hDEADBEEF);
        dirOp(32'h00000000, 32'h80000000, 1'b0, 3'b101, 31'h0, 32'hDEADBEEF);
        dirOp(32'h3F800000, 32'h40A00000, 1'b1, 3'b110, 31'h40A00000, 32'hDEADBEEF);
        dirOp(32'h40A00000, 32'h40A00000, 1'b1, 3'b111, 31'h0, 32'hDEADBEEF);
        dirOp(32'h7FC00001, 32'h3F800000, 1'b0, 3'b001, 31'h0, 32'hDEADBEEF);
        dirOp(32'h3F800000, 32'hC1200000, 1'b0, 3'b011, 31'h41200000, 32'hDEADBEEF);

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 32'h3F800000 + 32'(i), 32'hC0000000, 1'b0, 3'(i + 1),
                          31'(32'h40000000 + 32'(i)), 1'b0, '0, 1'b0);
        repeat (3) idleCycle();
        checkOutput("b2b_fifo_full", 32'(fifo_count), 32'd4);
        checkOutput("b2b_overflow", 32'(err_overflow), 32'd1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, $urandom, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 32'h12345678, 1'b0);
        idleCycle();
        checkOutput("underflow_set", 32'(err_underflow), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        idleCycle();
        checkOutput("clr_err", {30'h0, err_overflow, err_underflow}, 32'h0);

        repeat (3) idleCycle();
        checkOutput("scoreboard_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
